// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the fetch/decode decoupling queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int XLEN = 32;

  // Decode issues this when no bundle is available (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] instr;
  } fetch_bundle_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module   : fetch_queue_if
// Brief    : Enqueue/dequeue handshake bundle between fetch, queue and decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = fetch_pkg::XLEN
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [XLEN-1:0] enq_pc_next;
  logic [XLEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [XLEN-1:0] deq_pc_next;
  logic [XLEN-1:0] deq_instr;
  logic [CW-1:0]   count;

  modport master (
    output flush, enq_valid, enq_pc, enq_pc_next, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_pc_next, deq_instr, count
  );

  modport slave (
    input  flush, enq_valid, enq_pc, enq_pc_next, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_pc_next, deq_instr, count
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_mem.sv
// ============================================================================
// Module   : fetch_queue_mem
// Brief    : DEPTH x WIDTH register array, one write port, async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  wire logic                     clk,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic      [WIDTH-1:0]         rdata_o
);

  // Intentionally not reset: the queue masks outputs whenever nothing is valid.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular-buffer FIFO decoupling instruction fetch from decode,
//            flushed on redirect. Optional zero-latency empty-queue bypass
//            enabled by defining FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  fetch_queue_if.slave q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  fetch_bundle_t enq_bundle;
  fetch_bundle_t head_bundle;
  fetch_bundle_t mem_rdata;
  logic          bypass;
  logic          enq_fire;
  logic          deq_fire;
  logic          wr_en;
  logic          rd_adv;

  assign enq_bundle = '{pc:      q_if.enq_pc,
                        pc_next: q_if.enq_pc_next,
                        instr:   q_if.enq_instr};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && q_if.enq_valid && !q_if.flush;
`else
  assign bypass = 1'b0;
`endif

  assign q_if.enq_ready = (count_q != FULL_CNT) && !q_if.flush;
  assign q_if.deq_valid = ((count_q != '0) || bypass) && !q_if.flush;

  assign enq_fire = q_if.enq_valid && q_if.enq_ready;
  assign deq_fire = q_if.deq_valid && q_if.deq_ready;

  // A bypassed bundle consumed in the same cycle never touches storage.
  assign wr_en  = enq_fire && !(bypass && q_if.deq_ready);
  assign rd_adv = deq_fire && !bypass;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_bundle_t))
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (enq_bundle),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign head_bundle = bypass ? enq_bundle : mem_rdata;

  assign q_if.deq_pc      = q_if.deq_valid ? head_bundle.pc      : '0;
  assign q_if.deq_pc_next = q_if.deq_valid ? head_bundle.pc_next : '0;
  assign q_if.deq_instr   = q_if.deq_valid ? head_bundle.instr   : '0;
  assign q_if.count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_bundle_t mdl[$];

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic fl, input logic ev, input logic dr,
                      input logic [31:0] pc, input logic [31:0] pcn, input logic [31:0] ins);
    int            sz;
    logic          byp;
    logic          e_rdy;
    logic          e_vld;
    fetch_bundle_t head;
    fetch_bundle_t nb;
    rst            = r;
    fq.flush       = fl;
    fq.enq_valid   = ev;
    fq.deq_ready   = dr;
    fq.enq_pc      = pc;
    fq.enq_pc_next = pcn;
    fq.enq_instr   = ins;
    #1;
    nb = '{pc: pc, pc_next: pcn, instr: ins};
    sz = mdl.size();
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && ev && !fl;
`else
    byp = 1'b0;
`endif
    e_rdy = (sz != DEPTH) && !fl;
    e_vld = ((sz != 0) || byp) && !fl;
    head  = byp ? nb : ((sz != 0) ? mdl[0] : '0);
    if (!e_vld) head = '0;
    chk("enq_ready",   96'(fq.enq_ready),   96'(e_rdy));
    chk("deq_valid",   96'(fq.deq_valid),   96'(e_vld));
    chk("count",       96'(fq.count),       96'(sz));
    chk("deq_pc",      96'(fq.deq_pc),      96'(head.pc));
    chk("deq_pc_next", 96'(fq.deq_pc_next), 96'(head.pc_next));
    chk("deq_instr",   96'(fq.deq_instr),   96'(head.instr));
    @(posedge clk);
    if (r || fl) begin
      mdl.delete();
    end else begin
      if (ev && e_rdy) mdl.push_back(nb);
      if (e_vld && dr) void'(mdl.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    fq.flush       = 1'b0;
    fq.enq_valid   = 1'b0;
    fq.deq_ready   = 1'b0;
    fq.enq_pc      = '0;
    fq.enq_pc_next = '0;
    fq.enq_instr   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_count",     96'(fq.count),     96'(0));
    chk("rst_deq_valid", 96'(fq.deq_valid), 96'(0));
    chk("rst_enq_ready", 96'(fq.enq_ready), 96'(1));
    chk("rst_deq_instr", 96'(fq.deq_instr), 96'(0));
    @(negedge clk);

    // Fill to full with decode stalled, then present a fifth bundle.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 4), 32'(i * 4 + 4), 32'h1000 + 32'(i));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h14, 32'h1004);
    chk("full_count",     96'(fq.count),     96'(4));
    chk("full_enq_ready", 96'(fq.enq_ready), 96'(0));

    // Full queue refuses even while a dequeue fires; then drain.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h14, 32'h1004);
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", 96'(fq.deq_pc), 96'(i * 4));
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    end
    chk("drained_valid", 96'(fq.deq_valid), 96'(0));
    chk("drained_count", 96'(fq.count),     96'(0));

    // Streaming with both sides ready.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'h104 + 32'(i * 4), $urandom);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    // Flush with count=3 while fetch is presenting.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, $urandom);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h20C, 32'h210, 32'hDEAD);
    chk("flush_count", 96'(fq.count), 96'(0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h44, 32'h0000_0513);
    chk("post_flush_pc", 96'(fq.deq_pc), 96'(32'h40));
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    // Reset during a simultaneous enqueue and dequeue with count=2.
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, $urandom);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h308, 32'h30C, 32'hBEEF);
    chk("rst_mid_count", 96'(fq.count),     96'(0));
    chk("rst_mid_valid", 96'(fq.deq_valid), 96'(0));
    chk("rst_mid_pc",    96'(fq.deq_pc),    96'(0));
    idle();

    // Empty queue, both sides ready.
    fq.enq_valid   = 1'b1;
    fq.deq_ready   = 1'b1;
    fq.enq_instr   = 32'h0050_0093;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_instr", 96'(fq.deq_instr), 96'(32'h0050_0093));
`else
    chk("nobypass_valid", 96'(fq.deq_valid), 96'(0));
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h50, 32'h54, 32'h0050_0093);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_count", 96'(fq.count), 96'(0));
`else
    chk("nobypass_instr", 96'(fq.deq_instr), 96'(32'h0050_0093));
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom_range(0, 2) != 0), $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
